// File: rtl/ibex_mem_arbiter.sv
// Two-to-one req/gnt/rvalid arbiter sharing one memory port between instruction fetch
// and data. An in-order source-ID FIFO steers each response back to its requester.
module ibex_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b1,
  parameter bit          RoundRobin     = 1'b1,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            instr_req_i,
  output logic            instr_gnt_o,
  output logic            instr_rvalid_o,
  input  logic [31:0]     instr_addr_i,
  output logic [31:0]     instr_rdata_o,
  output logic [6:0]      instr_rdata_intg_o,
  output logic            instr_err_o,
  input  logic            data_req_i,
  output logic            data_gnt_o,
  output logic            data_rvalid_o,
  input  logic            data_we_i,
  input  logic [3:0]      data_be_i,
  input  logic [31:0]     data_addr_i,
  input  logic [31:0]     data_wdata_i,
  input  logic [6:0]      data_wdata_intg_i,
  output logic [31:0]     data_rdata_o,
  output logic [6:0]      data_rdata_intg_o,
  output logic            data_err_o,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [31:0]     mem_addr_o,
  output logic [31:0]     mem_wdata_o,
  output logic [6:0]      mem_wdata_intg_o,
  input  logic [31:0]     mem_rdata_i,
  input  logic [6:0]      mem_rdata_intg_i,
  input  logic            mem_err_i,
  output logic [CntW-1:0] outstanding_o,
  output logic            spurious_rvalid_o
);

  localparam int unsigned IdxW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic [1:0] {ARB, LOCK_I, LOCK_D} state_e;

  state_e                    state_q, state_d;
  logic                      pref_data_q, pref_data_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  // Source IDs, head at bit 0: 1 = data, 0 = instruction.
  logic [MaxOutstanding-1:0] fifo_q, fifo_d;

  logic            stall, active, sel_data, push, pop;
  logic [IdxW-1:0] wr_idx;

  // Stall looks at the registered count only, so rvalid never feeds mem_req_o.
  assign stall = (cnt_q == CntW'(MaxOutstanding));

  always_comb begin
    active   = 1'b0;
    sel_data = 1'b0;
    if (!stall) begin
      unique case (state_q)
        ARB: begin
          active = instr_req_i | data_req_i;
          if (instr_req_i && data_req_i) sel_data = RoundRobin ? pref_data_q : DataPriority;
          else                           sel_data = data_req_i;
        end
        LOCK_I: begin
          active   = 1'b1;
          sel_data = 1'b0;
        end
        LOCK_D: begin
          active   = 1'b1;
          sel_data = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign push = active & mem_gnt_i;
  assign pop  = mem_rvalid_i & (cnt_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ARB;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB:           if (active && !mem_gnt_i) state_d = sel_data ? LOCK_D : LOCK_I;
      LOCK_I, LOCK_D: if (push) state_d = ARB;
      default:       state_d = ARB;
    endcase
  end

  always_comb begin
    mem_req_o        = active;
    mem_we_o         = 1'b0;
    mem_be_o         = 4'b0000;
    mem_addr_o       = 32'h0;
    mem_wdata_o      = 32'h0;
    mem_wdata_intg_o = 7'h0;
    instr_gnt_o      = push & ~sel_data;
    data_gnt_o       = push &  sel_data;
    if (active) begin
      if (sel_data) begin
        mem_we_o         = data_we_i;
        mem_be_o         = data_be_i;
        mem_addr_o       = data_addr_i;
        mem_wdata_o      = data_wdata_i;
        mem_wdata_intg_o = data_wdata_intg_i;
      end else begin
        mem_be_o   = 4'b1111;
        mem_addr_o = instr_addr_i;
      end
    end
  end

  always_comb begin
    pref_data_d = pref_data_q;
    if (RoundRobin && push) pref_data_d = ~sel_data;
  end

  // A same-cycle pop shifts the queue down, so the new ID lands one slot lower.
  always_comb begin
    cnt_d  = cnt_q + CntW'(push) - CntW'(pop);
    wr_idx = IdxW'(pop ? cnt_q - CntW'(1) : cnt_q);
    fifo_d = fifo_q;
    if (pop)  fifo_d = fifo_q >> 1;
    if (push) fifo_d[wr_idx] = sel_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pref_data_q <= DataPriority;
      cnt_q       <= '0;
      fifo_q      <= '0;
    end else begin
      pref_data_q <= pref_data_d;
      cnt_q       <= cnt_d;
      fifo_q      <= fifo_d;
    end
  end

  assign instr_rvalid_o     = pop & ~fifo_q[0];
  assign data_rvalid_o      = pop &  fifo_q[0];
  assign spurious_rvalid_o  = mem_rvalid_i & (cnt_q == '0);
  assign instr_rdata_o      = mem_rdata_i;
  assign instr_rdata_intg_o = mem_rdata_intg_i;
  assign instr_err_o        = mem_err_i;
  assign data_rdata_o       = mem_rdata_i;
  assign data_rdata_intg_o  = mem_rdata_intg_i;
  assign data_err_o         = mem_err_i;
  assign outstanding_o      = cnt_q;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed bench for ibex_mem_arbiter (default parameters: 2 outstanding, round-robin,
// data priority); expected values are worked out by hand per cycle.
module tb_ibex_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic [6:0]  instr_rdata_intg_o;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [6:0]  data_wdata_intg_i, data_rdata_intg_o;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o, mem_err_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [6:0]  mem_wdata_intg_o, mem_rdata_intg_i;
  logic [1:0]  outstanding_o;
  logic        spurious_rvalid_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  ibex_mem_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
    .instr_rdata_intg_o(instr_rdata_intg_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_wdata_intg_i(data_wdata_intg_i),
    .data_rdata_o(data_rdata_o), .data_rdata_intg_o(data_rdata_intg_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wdata_intg_o(mem_wdata_intg_o),
    .mem_rdata_i(mem_rdata_i), .mem_rdata_intg_i(mem_rdata_intg_i), .mem_err_i(mem_err_i),
    .outstanding_o(outstanding_o), .spurious_rvalid_o(spurious_rvalid_o)
  );

  // A requester must hold req until it is granted.
  a_instr_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_req_i && !instr_gnt_o |=> instr_req_i) else $error("instr_req dropped before gnt");
  a_data_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_req_i && !data_gnt_o |=> data_req_i) else $error("data_req dropped before gnt");

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    instr_req_i = 0; instr_addr_i = 0;
    data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0;
    data_wdata_i = 0; data_wdata_intg_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_rdata_intg_i = 0; mem_err_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_ni = 1;
    #2 rst_ni = 0;
    #1;
    chk("rst_outst", outstanding_o, 0);
    chk("rst_memreq", mem_req_o, 0);
    chk("rst_gnt", {instr_gnt_o, data_gnt_o}, 0);
    chk("rst_rvalid", {instr_rvalid_o, data_rvalid_o, spurious_rvalid_o}, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;

    // Instruction-only stream, grant every cycle, response one cycle later.
    instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1; #1;
    chk("t1_req0", {mem_req_o, instr_gnt_o, data_gnt_o}, 3'b110);
    chk("t1_addr0", mem_addr_o, 32'h100);
    chk("t1_fields0", {mem_we_o, mem_be_o}, 5'b01111);
    chk("t1_out0", outstanding_o, 0);
    tick(); instr_addr_i = 32'h104; mem_rvalid_i = 1; mem_rdata_i = 32'hA0; #1;
    chk("t1_addr1", mem_addr_o, 32'h104);
    chk("t1_rv1", {instr_gnt_o, instr_rvalid_o, data_rvalid_o}, 3'b110);
    chk("t1_rd1", instr_rdata_o, 32'hA0);
    chk("t1_out1", outstanding_o, 1);
    tick(); instr_addr_i = 32'h108; mem_rdata_i = 32'hA1; #1;
    chk("t1_addr2", mem_addr_o, 32'h108);
    chk("t1_rv2", {instr_gnt_o, instr_rvalid_o}, 2'b11);
    chk("t1_out2", outstanding_o, 1);
    tick(); instr_req_i = 0; instr_addr_i = 0; mem_rdata_i = 32'hA2; #1;
    chk("t1_rv3", {mem_req_o, instr_rvalid_o, data_rvalid_o}, 3'b010);
    chk("t1_idle_addr", mem_addr_o, 0);
    tick(); idle(); #1;
    chk("t1_out_end", outstanding_o, 0);

    // Both requesting: round-robin D, I, D, I with steered responses.
    do_reset();
    instr_req_i = 1; instr_addr_i = 32'h300;
    data_req_i = 1; data_addr_i = 32'h200; data_we_i = 1; data_be_i = 4'b0011;
    data_wdata_i = 32'hDEAD; data_wdata_intg_i = 7'h15; mem_gnt_i = 1; #1;
    chk("t2_g0", {instr_gnt_o, data_gnt_o}, 2'b01);
    chk("t2_addr0", mem_addr_o, 32'h200);
    chk("t2_fields0", {mem_we_o, mem_be_o}, 5'b10011);
    chk("t2_wd0", {mem_wdata_intg_o, mem_wdata_o}, {7'h15, 32'hDEAD});
    tick(); data_addr_i = 32'h204; data_we_i = 0; data_be_i = 4'b1111;
    mem_rvalid_i = 1; mem_rdata_i = 32'hB0; mem_rdata_intg_i = 7'h22; mem_err_i = 1; #1;
    chk("t2_g1", {instr_gnt_o, data_gnt_o}, 2'b10);
    chk("t2_addr1", mem_addr_o, 32'h300);
    chk("t2_wd1", {mem_we_o, mem_wdata_intg_o, mem_wdata_o}, 0);
    chk("t2_rv1", {instr_rvalid_o, data_rvalid_o}, 2'b01);
    chk("t2_rd1", {data_rdata_intg_o, data_rdata_o}, {7'h22, 32'hB0});
    chk("t2_err1", {instr_err_o, data_err_o, instr_rdata_o}, {2'b11, 32'hB0});
    tick(); instr_addr_i = 32'h304; mem_err_i = 0; #1;
    chk("t2_g2", {instr_gnt_o, data_gnt_o}, 2'b01);
    chk("t2_addr2", mem_addr_o, 32'h204);
    chk("t2_rv2", {instr_rvalid_o, data_rvalid_o}, 2'b10);
    tick(); data_req_i = 0; #1;
    chk("t2_g3", {instr_gnt_o, data_gnt_o, mem_addr_o}, {2'b10, 32'h304});
    chk("t2_rv3", {instr_rvalid_o, data_rvalid_o}, 2'b01);
    tick(); instr_req_i = 0; mem_gnt_i = 0; #1;
    chk("t2_rv4", {instr_rvalid_o, data_rvalid_o, mem_req_o}, 3'b100);
    tick(); idle(); #1;
    chk("t2_out_end", outstanding_o, 0);

    // One data transaction so the preference points at instruction.
    data_req_i = 1; data_addr_i = 32'h40; mem_gnt_i = 1; #1;
    chk("t3_pre_g", data_gnt_o, 1);
    tick(); idle(); mem_rvalid_i = 1; #1;
    chk("t3_pre_rv", data_rvalid_o, 1);
    // Data locked while ungranted; instruction must not steal the port.
    tick(); idle(); data_req_i = 1; data_addr_i = 32'h400; #1;
    chk("t3_c1", {mem_req_o, data_gnt_o, mem_addr_o}, {2'b10, 32'h400});
    tick(); instr_req_i = 1; instr_addr_i = 32'h500; #1;
    chk("t3_c2", {mem_req_o, instr_gnt_o, data_gnt_o, mem_addr_o}, {3'b100, 32'h400});
    tick(); #1;
    chk("t3_c3", {instr_gnt_o, data_gnt_o, mem_addr_o}, {2'b00, 32'h400});
    tick(); mem_gnt_i = 1; #1;
    chk("t3_c4", {instr_gnt_o, data_gnt_o, mem_addr_o}, {2'b01, 32'h400});
    tick(); data_req_i = 0; data_addr_i = 0; #1;
    chk("t3_c5", {instr_gnt_o, data_gnt_o, mem_addr_o}, {2'b10, 32'h500});
    chk("t3_out5", outstanding_o, 1);

    // Full at two outstanding: request withheld until the count drops.
    tick(); instr_addr_i = 32'h504; #1;
    chk("t4_full", {mem_req_o, instr_gnt_o, mem_addr_o}, 0);
    chk("t4_out", outstanding_o, 2);
    tick(); mem_rvalid_i = 1; #1;
    chk("t4_rv_nogo", {mem_req_o, instr_gnt_o, data_rvalid_o, instr_rvalid_o}, 4'b0010);
    tick(); mem_rvalid_i = 0; #1;
    chk("t4_reassert", {mem_req_o, instr_gnt_o, mem_addr_o}, {2'b11, 32'h504});
    chk("t4_out1", outstanding_o, 1);
    tick(); instr_req_i = 0; mem_rvalid_i = 1; #1;
    chk("t4_rvi0", {instr_rvalid_o, data_rvalid_o}, 2'b10);
    tick(); #1;
    chk("t4_rvi1", {instr_rvalid_o, data_rvalid_o}, 2'b10);
    tick(); idle(); #1;
    chk("t4_out_end", outstanding_o, 0);

    // Response with nothing outstanding.
    mem_rvalid_i = 1; #1;
    chk("t5_spur", {spurious_rvalid_o, instr_rvalid_o, data_rvalid_o}, 3'b100);
    tick(); mem_rvalid_i = 0; #1;
    chk("t5_spur_off", {spurious_rvalid_o, outstanding_o}, 0);

    // Asynchronous reset with two in flight.
    instr_req_i = 1; instr_addr_i = 32'h600; mem_gnt_i = 1; #1;
    chk("t6_g0", instr_gnt_o, 1);
    tick(); instr_addr_i = 32'h604; #1;
    chk("t6_g1", instr_gnt_o, 1);
    tick(); idle(); #1;
    chk("t6_out2", outstanding_o, 2);
    #2 rst_ni = 0; #1;
    chk("t6_rst_out", outstanding_o, 0);
    chk("t6_rst_req", {mem_req_o, instr_gnt_o, data_gnt_o, spurious_rvalid_o}, 0);
    @(posedge clk_i); #1 rst_ni = 1;
    instr_req_i = 1; instr_addr_i = 32'h700; data_req_i = 1; data_addr_i = 32'h800;
    mem_rvalid_i = 1; #1;
    chk("t6_late_spur", {spurious_rvalid_o, instr_rvalid_o, data_rvalid_o}, 3'b100);
    chk("t6_arb", {mem_req_o, mem_addr_o}, {1'b1, 32'h800});
    tick(); mem_rvalid_i = 0; mem_gnt_i = 1; #1;
    chk("t6_dg", {instr_gnt_o, data_gnt_o}, 2'b01);
    tick(); data_req_i = 0; #1;
    chk("t6_ig", {instr_gnt_o, data_gnt_o, mem_addr_o}, {2'b10, 32'h700});
    tick(); idle(); #1;
    chk("t6_out_end", outstanding_o, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
